// File: rtl/ped_pkg.sv
// ped_pkg
// Shared definitions for the pedestrian request controller:
//   - ped_state_t    : controller state encoding
//   - *_DEFAULT      : default values for DEBOUNCE, COOLDOWN_S and MAX_WAIT
//   - PRESS_COUNT_MAX: saturation value of the accepted-press counter
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } ped_state_t;

  localparam int DEBOUNCE_DEFAULT   = 2;
  localparam int COOLDOWN_S_DEFAULT = 4;
  localparam int MAX_WAIT_DEFAULT   = 30;

  localparam logic [3:0] PRESS_COUNT_MAX = 4'd15;

endpackage

// File: rtl/sync_debounce.sv
// sync_debounce
// Brings the asynchronous push-button into the clk_1Hz domain and turns a
// sustained press into a single press_accept pulse.
// Ports:
//   clk_1Hz      in  system tick, rising edge
//   reset        in  asynchronous, active-high
//   button_raw   in  raw button level, high = pressed
//   press_accept out one-cycle pulse, high in the cycle the hold counter
//                    is about to reach DEBOUNCE
module sync_debounce
  import ped_pkg::*;
#(
  parameter int DEBOUNCE = DEBOUNCE_DEFAULT
) (
  input  logic clk_1Hz,
  input  logic reset,
  input  logic button_raw,
  output logic press_accept
);

  localparam int HOLD_W = $clog2(DEBOUNCE + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(DEBOUNCE);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(DEBOUNCE - 1);

  logic              btn_meta;
  logic              btn_s;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        warm_cnt;
  logic              released;

  // Synchronizer, hold counter and release guard.
  // The synchronizer flops reset to "not pressed", so right after reset a
  // button that is still held would look like a fresh press. released only
  // goes high once the synchronizer has refilled (warm_cnt) and then shows
  // the button up, which forces a real release before the first accept.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      btn_meta <= 1'b0;
      btn_s    <= 1'b0;
      hold_cnt <= '0;
      warm_cnt <= 2'd0;
      released <= 1'b0;
    end else begin
      btn_meta <= button_raw;
      btn_s    <= btn_meta;
      if (!btn_s) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_MAX) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if (warm_cnt != 2'd2) begin
        warm_cnt <= warm_cnt + 2'd1;
      end else if (!btn_s) begin
        released <= 1'b1;
      end
    end
  end

  // Fires on the edge that brings the counter to DEBOUNCE, so the FSM can
  // register the press on that same edge. Saturation keeps it to one pulse.
  assign press_accept = released && btn_s && (hold_cnt == HOLD_PRE);

endmodule

// File: rtl/ped_request_ctrl.sv
// ped_request_ctrl
// Pedestrian request controller: debounces the push-button, raises a
// request to the traffic FSM, lights the wait lamp while pending, flags
// overdue requests and counts accepted presses.
// Ports:
//   clk_1Hz          in   system tick, rising edge
//   reset            in   asynchronous, active-high
//   button_raw       in   asynchronous push-button level
//   pedestrian_green in   walk indication from the traffic FSM
//   request          out  registered request to the traffic FSM
//   wait_led         out  registered "request pending" lamp
//   overdue          out  registered, pending for MAX_WAIT cycles
//   press_count      out  registered saturating count of accepted presses
module ped_request_ctrl
  import ped_pkg::*;
#(
  parameter int DEBOUNCE   = DEBOUNCE_DEFAULT,
  parameter int COOLDOWN_S = COOLDOWN_S_DEFAULT,
  parameter int MAX_WAIT   = MAX_WAIT_DEFAULT
) (
  input  logic       clk_1Hz,
  input  logic       reset,
  input  logic       button_raw,
  input  logic       pedestrian_green,
  output logic       request,
  output logic       wait_led,
  output logic       overdue,
  output logic [3:0] press_count
);

  localparam int COOL_W = $clog2(COOLDOWN_S + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [COOL_W-1:0] COOL_LOAD  = COOL_W'(COOLDOWN_S);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

  ped_state_t        state, state_next;
  logic [COOL_W-1:0] cool_cnt, cool_next;
  logic [WAIT_W-1:0] wait_cnt, wait_next;
  logic [3:0]        count_next;
  logic              request_next, wait_led_next, overdue_next;
  logic              press_accept;

  sync_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_sync_debounce (
    .clk_1Hz     (clk_1Hz),
    .reset       (reset),
    .button_raw  (button_raw),
    .press_accept(press_accept)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk_1Hz or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cool_cnt    <= '0;
      wait_cnt    <= '0;
      press_count <= 4'd0;
      request     <= 1'b0;
      wait_led    <= 1'b0;
      overdue     <= 1'b0;
    end else begin
      state       <= state_next;
      cool_cnt    <= cool_next;
      wait_cnt    <= wait_next;
      press_count <= count_next;
      request     <= request_next;
      wait_led    <= wait_led_next;
      overdue     <= overdue_next;
    end
  end

  // Next-state logic. Outputs are decoded from the next state so they
  // change on the same edge as the state itself.
  always_comb begin
    state_next = state;
    cool_next  = cool_cnt;
    wait_next  = wait_cnt;
    count_next = press_count;

    case (state)
      IDLE: begin
        if (press_accept && !pedestrian_green) begin
          state_next = ARMED;
          wait_next  = '0;
          if (press_count != PRESS_COUNT_MAX) begin
            count_next = press_count + 4'd1;
          end
        end
      end
      ARMED: begin
        if (pedestrian_green) begin
          state_next = SERVING;
          wait_next  = '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
          wait_next = wait_cnt + WAIT_W'(1);
        end
      end
      SERVING: begin
        if (!pedestrian_green) begin
          state_next = COOLDOWN;
          cool_next  = COOL_LOAD;
        end
      end
      COOLDOWN: begin
        // The edge that would bring the counter to zero is the exit edge;
        // an accept landing on it is dropped because the state is still
        // COOLDOWN while it is decoded.
        if (cool_cnt > COOL_W'(1)) begin
          cool_next = cool_cnt - COOL_W'(1);
        end else begin
          cool_next  = '0;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cool_next  = '0;
        wait_next  = '0;
      end
    endcase

    request_next  = (state_next == ARMED);
    wait_led_next = (state_next == ARMED);
    overdue_next  = (state_next == ARMED) && (wait_next == WAIT_LIMIT);
  end

endmodule

// File: tb/tb_ped_request_ctrl.sv
// tb_ped_request_ctrl
// Self-checking bench for ped_request_ctrl with default parameters
// (DEBOUNCE=2, COOLDOWN_S=4, MAX_WAIT=30). Each scenario builds a table of
// per-edge inputs and hand-derived expected outputs; expectations go into
// a scoreboard queue as the inputs are driven and are popped and compared
// one time unit after the clock edge.
module tb_ped_request_ctrl;

  logic       clk_1Hz = 1'b0;
  logic       reset = 1'b0;
  logic       button_raw = 1'b0;
  logic       pedestrian_green = 1'b0;
  logic       request;
  logic       wait_led;
  logic       overdue;
  logic [3:0] press_count;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic       btn;
    logic       grn;
    logic       req;
    logic       wl;
    logic       od;
    logic [3:0] cnt;
  } step_t;

  typedef struct {
    string      tag;
    int         idx;
    logic       req;
    logic       wl;
    logic       od;
    logic [3:0] cnt;
  } exp_t;

  step_t plan[$];
  exp_t  sb[$];

  ped_request_ctrl dut (
    .clk_1Hz         (clk_1Hz),
    .reset           (reset),
    .button_raw      (button_raw),
    .pedestrian_green(pedestrian_green),
    .request         (request),
    .wait_led        (wait_led),
    .overdue         (overdue),
    .press_count     (press_count)
  );

  always #5 clk_1Hz = ~clk_1Hz;

  task automatic tick();
    @(posedge clk_1Hz);
    #1;
  endtask

  // Append n identical edges to the plan: inputs sampled at the edge and
  // the outputs expected just after it.
  task automatic add(input logic btn, input logic grn, input logic req,
                     input logic wl, input logic od, input logic [3:0] cnt,
                     input int n);
    step_t s;
    s.btn = btn; s.grn = grn; s.req = req; s.wl = wl; s.od = od; s.cnt = cnt;
    for (int k = 0; k < n; k++) plan.push_back(s);
  endtask

  // Drive one planned edge and queue its expectation.
  task automatic drive_step(input string tag, input int i);
    exp_t e;
    button_raw       = plan[i].btn;
    pedestrian_green = plan[i].grn;
    e.tag = tag; e.idx = i;
    e.req = plan[i].req; e.wl = plan[i].wl; e.od = plan[i].od; e.cnt = plan[i].cnt;
    sb.push_back(e);
    tick();
  endtask

  task automatic do_reset();
    button_raw       = 1'b0;
    pedestrian_green = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    exp_t e;
    button_raw       = 1'b0;
    pedestrian_green = 1'b0;
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({request, wait_led, overdue, press_count} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_async: got req/wl/od/cnt %b/%b/%b/%0d expected 0/0/0/0",
               request, wait_led, overdue, press_count);
    end
    #1 reset = 1'b0;
    plan.delete();
    add(0, 0, 0, 0, 0, 4'd0, 4);
    foreach (plan[i]) begin
      drive_step("reset_idle", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // Held press: request and count appear after edge 3 and stay.
  task automatic test_press_latency();
    exp_t e;
    do_reset();
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 3);
    add(1, 0, 1, 1, 0, 4'd1, 7);
    foreach (plan[i]) begin
      drive_step("press_latency", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // ARMED re-press ignored, serve, cooldown length and the exit-edge accept.
  task automatic test_serve_cooldown();
    exp_t e;
    do_reset();
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 3);
    add(1, 0, 1, 1, 0, 4'd1, 1);
    add(0, 0, 1, 1, 0, 4'd1, 2);
    add(1, 0, 1, 1, 0, 4'd1, 5);   // re-press while ARMED: not counted
    add(0, 0, 1, 1, 0, 4'd1, 1);
    add(0, 1, 0, 0, 0, 4'd1, 2);   // walk: request drops on that edge
    add(0, 0, 0, 0, 0, 4'd1, 1);   // edge m: walk ends
    add(1, 0, 0, 0, 0, 4'd1, 9);   // accept lands on edge m+4: ignored
    add(0, 0, 0, 0, 0, 4'd1, 2);
    add(1, 0, 0, 0, 0, 4'd1, 3);
    add(1, 0, 1, 1, 0, 4'd2, 1);
    add(0, 0, 1, 1, 0, 4'd2, 1);
    add(0, 1, 0, 0, 0, 4'd2, 2);
    add(0, 0, 0, 0, 0, 4'd2, 2);   // edges m, m+1
    add(1, 0, 0, 0, 0, 4'd2, 3);   // accept lands on edge m+5: taken
    add(1, 0, 1, 1, 0, 4'd3, 2);
    foreach (plan[i]) begin
      drive_step("serve_cooldown", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // One-cycle press is rejected, two-cycle press is accepted.
  task automatic test_short_press();
    exp_t e;
    do_reset();
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 1);
    add(0, 0, 0, 0, 0, 4'd0, 5);
    add(1, 0, 0, 0, 0, 4'd0, 2);
    add(0, 0, 0, 0, 0, 4'd0, 1);
    add(0, 0, 1, 1, 0, 4'd1, 3);
    foreach (plan[i]) begin
      drive_step("short_press", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // overdue rises 30 edges after ARMED entry, drops with the walk, and is
  // clear again on the next ARMED visit.
  task automatic test_overdue();
    exp_t e;
    do_reset();
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 3);
    add(1, 0, 1, 1, 0, 4'd1, 1);
    add(0, 0, 1, 1, 0, 4'd1, 29);
    add(0, 0, 1, 1, 1, 4'd1, 3);
    add(0, 1, 0, 0, 0, 4'd1, 2);
    add(0, 0, 0, 0, 0, 4'd1, 5);
    add(1, 0, 0, 0, 0, 4'd1, 3);
    add(1, 0, 1, 1, 0, 4'd2, 2);
    foreach (plan[i]) begin
      drive_step("overdue", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // 20 full press/serve/cooldown rounds; count sticks at 15.
  task automatic test_saturation();
    exp_t e;
    do_reset();
    plan.delete();
    for (int r = 1; r <= 20; r++) begin
      int c;
      int cp;
      c  = (r > 15) ? 15 : r;
      cp = (r - 1 > 15) ? 15 : r - 1;
      add(1, 0, 0, 0, 0, 4'(cp), 3);
      add(1, 0, 1, 1, 0, 4'(c), 1);
      add(0, 1, 0, 0, 0, 4'(c), 1);
      add(0, 0, 0, 0, 0, 4'(c), 5);
    end
    foreach (plan[i]) begin
      drive_step("saturation", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  // Reset between edges while ARMED; a still-held button must not re-arm.
  task automatic test_reset_mid_armed();
    exp_t e;
    do_reset();
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 3);
    add(1, 0, 1, 1, 0, 4'd1, 2);
    foreach (plan[i]) begin
      drive_step("pre_reset_armed", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({request, wait_led, overdue, press_count} !== 7'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_armed: got req/wl/od/cnt %b/%b/%b/%0d expected 0/0/0/0",
               request, wait_led, overdue, press_count);
    end
    #1 reset = 1'b0;
    plan.delete();
    add(1, 0, 0, 0, 0, 4'd0, 8);   // still held after release: ignored
    add(0, 0, 0, 0, 0, 4'd0, 2);
    add(1, 0, 0, 0, 0, 4'd0, 3);
    add(1, 0, 1, 1, 0, 4'd1, 1);
    foreach (plan[i]) begin
      drive_step("post_reset_hold", i);
      e = sb.pop_front();
      tests++;
      if ({request, wait_led, overdue, press_count} !== {e.req, e.wl, e.od, e.cnt}) begin
        fails++;
        $display("[TB] FAIL %s step %0d: got req/wl/od/cnt %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 e.tag, e.idx, request, wait_led, overdue, press_count, e.req, e.wl, e.od, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_serve_cooldown();
    test_short_press();
    test_overdue();
    test_saturation();
    test_reset_mid_armed();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ped_request_ctrl.md
PED_REQUEST_CTRL -- requirements
Module: ped_request_ctrl

Interface
REQ-001 Parameter DEBOUNCE, default 2: consecutive synchronized high samples needed to accept a press (range 1..7).
REQ-002 Parameter COOLDOWN_S, default 4: clk_1Hz cycles after walk ends during which presses are ignored (range 1..15).
REQ-003 Parameter MAX_WAIT, default 30: clk_1Hz cycles in ARMED after which overdue asserts (range 1..63).
REQ-004 clk_1Hz  input  1  system tick; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 button_raw  input  1  asynchronous pedestrian push-button level, high = pressed.
REQ-007 pedestrian_green  input  1  walk indication from the traffic FSM, synchronous to clk_1Hz.
REQ-008 request  output  1  registered pedestrian request to the traffic FSM.
REQ-009 wait_led  output  1  registered "request pending" lamp.
REQ-010 overdue  output  1  registered; request pending at least MAX_WAIT cycles.
REQ-011 press_count  output  4  registered count of accepted presses, saturating.

Function
REQ-012 button_raw SHALL pass a 2-flop synchronizer; only the second flop (btn_s) feeds logic.
REQ-013 A hold counter SHALL increment while btn_s=1, saturate at DEBOUNCE, and clear while btn_s=0.
REQ-014 A press is accepted in the cycle the hold counter reaches DEBOUNCE; at most one accept per press, and a new accept requires btn_s=0 for at least one cycle.
REQ-015 With button_raw held high from edge k, request SHALL be high after edge k+1+DEBOUNCE (edge k+3 for DEBOUNCE=2).
REQ-016 FSM states: IDLE, ARMED, SERVING, COOLDOWN.
REQ-017 IDLE: an accepted press with pedestrian_green=0 -> ARMED and press_count+1; with pedestrian_green=1 the press is ignored and not counted.
REQ-018 ARMED: request=1 and wait_led=1; pedestrian_green=1 -> SERVING, with request low from that edge; further presses are ignored and not counted.
REQ-019 SERVING: request=0; pedestrian_green=0 -> COOLDOWN with the cooldown counter loaded to COOLDOWN_S.
REQ-020 COOLDOWN: the counter decrements each cycle; on reaching 0 -> IDLE, so IDLE is entered exactly COOLDOWN_S cycles after SERVING exit; presses are ignored.
REQ-021 An accept in the same cycle as COOLDOWN->IDLE SHALL be ignored; the button must be released and re-pressed.
REQ-022 The wait counter SHALL clear on ARMED entry and count each ARMED cycle, saturating at MAX_WAIT; overdue=1 once it equals MAX_WAIT, cleared on ARMED exit.
REQ-023 press_count SHALL saturate at 15 and never wrap.
REQ-024 request, wait_led and overdue SHALL be zero in every state other than ARMED.
REQ-025 An illegal state encoding SHALL return to IDLE on the next edge.

Reset
REQ-026 On reset: state=IDLE; request, wait_led and overdue = 0; press_count = 0; synchronizer, hold, cooldown and wait counters = 0; all take effect immediately, independent of the clock.
REQ-027 Reset asserted mid-ARMED SHALL drop request immediately; after release a fresh press is required.

Structure
REQ-028 Package ped_pkg SHALL hold the state enum type and the default values of DEBOUNCE, COOLDOWN_S and MAX_WAIT.
REQ-029 Sub-module sync_debounce SHALL contain the synchronizer, hold counter and single-accept logic (REQ-012..REQ-014) and output a one-cycle press_accept pulse.
REQ-030 Counter widths SHALL be derived from the parameters with $clog2.

Verification
REQ-031 button_raw high from edge 0 (default parameters) -> request=1 and press_count=1 after edge 3; with button held and no walk, request stays 1.
REQ-032 ARMED, pedestrian_green=1 at edge n -> request=0 after edge n; pedestrian_green=0 at edge m -> state IDLE after edge m+4; a press during edges m..m+3 -> request stays 0 and press_count is unchanged.
REQ-033 button_raw high for 1 cycle only -> no request and press_count=0; high for 2 cycles -> request=1.
REQ-034 ARMED held 30 cycles with no walk -> overdue=1 on cycle 30; walk arrives -> overdue=0 and request=0 on the same edge.
REQ-035 20 accepted press/serve cycles -> press_count=15 throughout the final 5 cycles.
REQ-036 reset asserted mid-ARMED between clock edges -> request, wait_led, overdue and press_count = 0 immediately; button still held after release -> no new request until released and re-pressed.
